fft_frame_streamer: RTL and testbench

Streams one frame of complex samples from a local sample RAM into the Avalon-ST sink of the variable-size streaming FFT core. The block generates the read addresses, absorbs the RAM's 1-cycle read latency with a 2-entry skid FIFO, and drives sink-side valid/sop/eop/fftpts while honouring the core's ready backpressure. It sits between the charge-grid line buffers and the FFT core, one instance per FFT lane.

---
 rtl/fft_stream_pkg.sv | 32 +++
 rtl/stream_skid_fifo2.sv | 58 +++++
 rtl/fft_frame_streamer.sv | 175 +++++++++++++++++
 tb/tb_fft_frame_streamer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_stream_pkg.sv
// fft_stream_pkg
// Shared definitions for the FFT streaming blocks. This package is used by
// fft_frame_streamer on the sink side and by the output-side FFT consumer.
//   DEFAULT_*      : default widths and limits for the FFT lane
//   stream_state_t : frame sequencer states
//   pts_is_legal() : tells whether a requested frame length is legal
package fft_stream_pkg;

    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_PTS_W   = 7;
    localparam int DEFAULT_MAX_PTS = 64;
    localparam int DEFAULT_ADDR_W  = 6;

    // IDLE  : waiting for start
    // READ  : some RAM addresses are still to be issued
    // DRAIN : every read is issued, but beats are still in flight or queued
    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } stream_state_t;

    // The core accepts only powers of two from 4 up to the configured maximum.
    // A power of two has exactly one bit set, so clearing the lowest set bit
    // leaves zero.
    function automatic logic pts_is_legal(input logic [DEFAULT_PTS_W-1:0] pts,
                                          input int                       max_pts);
        return (int'(pts) >= 4) && (int'(pts) <= max_pts) &&
               ((pts & (pts - DEFAULT_PTS_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/stream_skid_fifo2.sv
// stream_skid_fifo2
// Two-entry registered FIFO. It absorbs the one-cycle RAM read latency so the
// sink can stall without losing a read that is already in flight.
//   clk, rst         : clock, synchronous active-high reset (flushes contents)
//   push, wr_data    : write request and payload
//   pop              : read request; the head is rd_data while !empty
//   rd_data          : head-of-queue payload
//   count            : number of entries held (0..2)
//   empty, full      : occupancy flags
module stream_skid_fifo2 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic [1:0]   count,
    output logic         empty,
    output logic         full
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    // A push into a full queue is only safe when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage, pointers and occupancy. Storage is cleared on reset so that the
    // head reads as zero while the queue is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/fft_frame_streamer.sv
// fft_frame_streamer
// Streams one frame of complex samples from the local sample RAM into the
// Avalon-ST sink of the streaming FFT core. It honours sink backpressure.
//   clk, rst                : clock, synchronous active-high reset
//   start, frame_pts,
//   base_addr               : frame request. Length and base are sampled with start.
//   busy, done, cfg_err     : status. done and cfg_err are one-cycle pulses.
//   rd_en, rd_addr,
//   rd_real, rd_imag        : sample RAM port. Data returns one cycle after rd_en.
//   out_valid, out_ready,
//   out_sop, out_eop,
//   out_error, out_real,
//   out_imag, out_fftpts    : FFT core sink interface
module fft_frame_streamer
    import fft_stream_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int PTS_W   = DEFAULT_PTS_W,
    parameter int MAX_PTS = DEFAULT_MAX_PTS,
    parameter int ADDR_W  = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PTS_W-1:0]  frame_pts,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_real,
    input  logic [DATA_W-1:0] rd_imag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic [1:0]        out_error,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic [PTS_W-1:0]  out_fftpts
);

    stream_state_t       state_q, state_d;
    logic [ADDR_W-1:0]   base_q;
    logic [PTS_W-1:0]    pts_q;
    logic [PTS_W-1:0]    rd_idx;
    logic [PTS_W-1:0]    out_idx;
    logic                inflight_q;
    logic                done_q;
    logic                cfg_err_q;

    logic                start_ok;
    logic                start_bad;
    logic                issue;
    logic                beat;
    logic                credit_ok;

    logic [2*DATA_W-1:0] fifo_head;
    logic [1:0]          fifo_count;
    logic                fifo_empty;
    logic                fifo_full;

    // Returned RAM data always lands in the FIFO the cycle after its read.
    // The credit rule keeps room for it, so the FIFO never overflows.
    stream_skid_fifo2 #(
        .W (2*DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (inflight_q),
        .wr_data ({rd_real, rd_imag}),
        .pop     (beat),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign out_valid  = !fifo_empty;
    assign beat       = out_valid && out_ready;
    assign out_real   = fifo_head[2*DATA_W-1:DATA_W];
    assign out_imag   = fifo_head[DATA_W-1:0];
    assign out_sop    = out_valid && (out_idx == '0);
    assign out_eop    = out_valid && (out_idx == pts_q - PTS_W'(1));
    assign out_error  = 2'b00;
    assign out_fftpts = pts_q;

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign cfg_err = cfg_err_q;
    assign rd_en   = issue;
    assign rd_addr = base_q + ADDR_W'(rd_idx);

    // A new read may issue only if the queued beats, plus the read already in
    // flight, minus the beat leaving this cycle, leave a slot free for it.
    assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, beat}) <= 3'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, start qualification and read issue. A start in the
    // cycle that shows done is ignored. Starts are also ignored outside IDLE.
    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        issue     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    if (pts_is_legal(frame_pts, MAX_PTS)) begin
                        start_ok = 1'b1;
                        state_d  = READ;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            READ: begin
                if (credit_ok && !fifo_full) begin
                    issue = 1'b1;
                    if (rd_idx == pts_q - PTS_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (beat && out_eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame bookkeeping: latched request, read and beat counters, the
    // in-flight read flag, and the status pulses. Reset drops any read that
    // is still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            pts_q      <= '0;
            rd_idx     <= '0;
            out_idx    <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            inflight_q <= issue;
            done_q     <= (state_q == DRAIN) && beat && out_eop;
            cfg_err_q  <= start_bad;
            if (start_ok) begin
                base_q  <= base_addr;
                pts_q   <= frame_pts;
                rd_idx  <= '0;
                out_idx <= '0;
            end else begin
                if (issue) begin
                    rd_idx <= rd_idx + PTS_W'(1);
                end
                if (beat) begin
                    out_idx <= out_idx + PTS_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_streamer.sv
// tb_fft_frame_streamer
// Directed bench for fft_frame_streamer. A behavioural sample RAM returns
// data one cycle after rd_en. Each sample word encodes its own address, so
// every accepted beat can be predicted from base + beat index.
module tb_fft_frame_streamer;

    localparam int DATA_W  = 32;
    localparam int PTS_W   = 7;
    localparam int MAX_PTS = 64;
    localparam int ADDR_W  = 6;

    logic              clk;
    logic              rst;
    logic              start;
    logic [PTS_W-1:0]  frame_pts;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_real;
    logic [DATA_W-1:0] rd_imag;
    logic              out_valid;
    logic              out_ready;
    logic              out_sop;
    logic              out_eop;
    logic [1:0]        out_error;
    logic [DATA_W-1:0] out_real;
    logic [DATA_W-1:0] out_imag;
    logic [PTS_W-1:0]  out_fftpts;

    int assert_count = 0;
    int fail_count   = 0;
    int rd_total     = 0;
    int done_total   = 0;
    int sop_total    = 0;
    logic overflow_seen = 1'b0;

    fft_frame_streamer #(
        .DATA_W  (DATA_W),
        .PTS_W   (PTS_W),
        .MAX_PTS (MAX_PTS),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .frame_pts  (frame_pts),
        .base_addr  (base_addr),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_real    (rd_real),
        .rd_imag    (rd_imag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_error  (out_error),
        .out_real   (out_real),
        .out_imag   (out_imag),
        .out_fftpts (out_fftpts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM contents are a fixed function of the address.
    function automatic logic [DATA_W-1:0] ram_real_at(input logic [ADDR_W-1:0] a);
        return {16'hC0DE, 10'h000, a};
    endfunction

    function automatic logic [DATA_W-1:0] ram_imag_at(input logic [ADDR_W-1:0] a);
        return {16'hBEEF, 4'h0, a, 6'h00};
    endfunction

    // Sample RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_real <= ram_real_at(rd_addr);
            rd_imag <= ram_imag_at(rd_addr);
        end
    end

    // Running totals of reads, done pulses and accepted sop beats, plus a
    // sticky flag for a push into a full FIFO that no pop relieves.
    always @(posedge clk) begin
        if (rd_en) rd_total <= rd_total + 1;
        if (done) done_total <= done_total + 1;
        if (out_valid && out_ready && out_sop) sop_total <= sop_total + 1;
        if (!rst && dut.u_fifo.push && dut.u_fifo.full && !dut.u_fifo.pop) overflow_seen <= 1'b1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    function automatic logic [95:0] out_vector();
        return 96'({busy, done, cfg_err, rd_en, rd_addr, out_valid, out_sop, out_eop,
                    out_error, out_real, out_imag, out_fftpts});
    endfunction

    task automatic checkOutput(input string tag, input logic [95:0] observed,
                               input logic [95:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents a start request at the current falling edge and holds it for
    // exactly one rising edge.
    task automatic applyStimulus(input logic [PTS_W-1:0] pts, input logic [ADDR_W-1:0] base);
        start     = 1'b1;
        frame_pts = pts;
        base_addr = base;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one frame and checks every accepted beat, data held across stalls,
    // the done pulse timing and, with ready held high, the exact latency.
    // With poke_starts set, it also fires a start mid-frame and one in the
    // done cycle. Neither start may have any effect.
    task automatic streamFrame(input string tag, input int n, input logic [ADDR_W-1:0] base,
                               input bit random_ready, input bit poke_starts);
        int                k;
        int                cyc;
        int                first_valid;
        int                eop_cyc;
        int                done_cyc;
        int                done_before;
        int                sop_before;
        bit                have_hold;
        logic [95:0]       hold_vec;
        logic [ADDR_W-1:0] a;
        k           = 0;
        first_valid = -1;
        eop_cyc     = -1;
        done_cyc    = -1;
        have_hold   = 1'b0;
        hold_vec    = '0;
        done_before = done_total;
        sop_before  = sop_total;
        applyStimulus(PTS_W'(n), base);
        checkOutput({tag, "_first_read"}, 96'({busy, rd_en, rd_addr}), 96'({1'b1, 1'b1, base}));
        cyc = 1;
        while (done_cyc < 0 && cyc <= n * 4 + 40) begin
            if (poke_starts) begin
                start = (cyc == 6);
                if (cyc == 6) begin
                    frame_pts = PTS_W'(8);
                    base_addr = base + ADDR_W'(1);
                end
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (have_hold) begin
                checkOutput({tag, "_stall_hold"},
                            96'({out_valid, out_sop, out_eop, out_real, out_imag}), hold_vec);
                have_hold = 1'b0;
            end
            if (done) begin
                done_cyc = cyc;
                checkOutput({tag, "_busy_at_done"}, 96'(busy), 96'(0));
                if (poke_starts) begin
                    start     = 1'b1;
                    frame_pts = PTS_W'(8);
                    base_addr = base;
                end
            end
            out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                a = base + ADDR_W'(k);
                checkOutput({tag, "_beat"},
                            96'({out_sop, out_eop, out_fftpts, out_real, out_imag}),
                            96'({k == 0, k == n - 1, PTS_W'(n), ram_real_at(a), ram_imag_at(a)}));
                if (k == n - 1) eop_cyc = cyc;
                k++;
            end else if (out_valid) begin
                have_hold = 1'b1;
                hold_vec  = 96'({out_valid, out_sop, out_eop, out_real, out_imag});
            end
            if (done_cyc < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput({tag, "_beat_count"}, 96'(k), 96'(n));
        checkOutput({tag, "_done_seen"}, 96'(done_cyc >= 0), 96'(1));
        checkOutput({tag, "_done_after_eop"}, 96'(done_cyc - eop_cyc), 96'(1));
        if (!random_ready) begin
            checkOutput({tag, "_first_valid_cycle"}, 96'(first_valid), 96'(3));
            checkOutput({tag, "_done_cycle"}, 96'(done_cyc), 96'(n + 3));
        end
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b1;
        if (poke_starts) begin
            checkOutput({tag, "_done_start_ignored"}, 96'({busy, rd_en}), 96'(0));
            checkOutput({tag, "_frame_count"}, 96'({16'(done_total - done_before),
                                                     16'(sop_total - sop_before)}),
                        96'({16'd1, 16'd1}));
        end
    endtask

    initial begin
        int rd_before;
        rst       = 1'b1;
        start     = 1'b0;
        frame_pts = '0;
        base_addr = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", out_vector(), 96'(0));
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] full 64-point frame from address 0");
        streamFrame("f64", 64, 6'd0, 1'b0, 1'b0);

        $display("[TB] 8-point frame wrapping from address 60");
        streamFrame("f8wrap", 8, 6'd60, 1'b0, 1'b0);

        $display("[TB] 16-point frame with random backpressure");
        streamFrame("f16bp", 16, 6'd10, 1'b1, 1'b0);

        $display("[TB] illegal frame lengths");
        rd_before = rd_total;
        applyStimulus(PTS_W'(12), 6'd0);
        checkOutput("cfg12_err", 96'({cfg_err, busy}), 96'({1'b1, 1'b0}));
        @(negedge clk);
        checkOutput("cfg12_pulse_end", 96'({cfg_err, busy}), 96'(0));
        // 128 does not fit the 7-bit length field and arrives as 0.
        applyStimulus(PTS_W'(128), 6'd0);
        checkOutput("cfg128_err", 96'({cfg_err, busy}), 96'({1'b1, 1'b0}));
        @(negedge clk);
        checkOutput("cfg128_pulse_end", 96'({cfg_err, busy}), 96'(0));
        checkOutput("cfg_no_reads", 96'(rd_total - rd_before), 96'(0));

        $display("[TB] starts mid-frame and in the done cycle");
        streamFrame("f16poke", 16, 6'd3, 1'b0, 1'b1);

        $display("[TB] reset in the middle of a 32-point frame");
        applyStimulus(PTS_W'(32), 6'd0);
        repeat (12) @(negedge clk);
        checkOutput("rst_beat10", 96'({out_valid, out_real}), 96'({1'b1, ram_real_at(6'd10)}));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_midframe", out_vector(), 96'(0));
        rst = 1'b0;
        @(negedge clk);
        streamFrame("post_rst", 8, 6'd20, 1'b0, 1'b0);

        checkOutput("fifo_overflow", 96'(overflow_seen), 96'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
